// File: rtl/clock_divider_multi.sv
// clock_divider_multi: N-channel programmable 50%-duty clock divider with a
// global single-step mode gated by channel 0 (the CPU clock).
module clock_divider_multi #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] div_load,
    input  logic [WIDTH-1:0]    div_value,
    input  logic [CHANNELS-1:0] enable,
    input  logic                step_mode,
    input  logic                step_req,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick,
    output logic                busy
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    typedef enum logic {IDLE, STEP} state_t;

    state_t              state_q, state_d;
    logic                seen_q, seen_d;
    logic                req_q;
    logic                req_rise;

    logic [WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [WIDTH-1:0]    cnt_d   [CHANNELS];
    logic [WIDTH-1:0]    div_q   [CHANNELS];
    logic [WIDTH-1:0]    div_d   [CHANNELS];
    logic [WIDTH-1:0]    limit   [CHANNELS];
    logic [CHANNELS-1:0] clk_q, clk_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] fall_d;
    logic [CHANNELS-1:0] adv;

    // Per-channel divider next state: disable clears, load beats advance.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            clk_d[i]  = clk_q[i];
            tick_d[i] = 1'b0;
            fall_d[i] = 1'b0;
            limit[i]  = (div_q[i] == '0) ? '0 : div_q[i] - ONE;
            adv[i]    = enable[i] && (!step_mode || state_q == STEP);
            if (!enable[i]) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                if (div_load[i]) begin
                    div_d[i] = div_value;
                end
            end else if (div_load[i]) begin
                div_d[i] = div_value;
                cnt_d[i] = '0;
            end else if (adv[i]) begin
                if (cnt_q[i] >= limit[i]) begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = ~clk_q[i];
                    fall_d[i] = clk_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clock_in) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
                div_q[i] <= DIV_RST;
            end else begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
        end
        if (reset) begin
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign req_rise = step_req && !req_q;

    // Step FSM next state: a step ends on the first ch0 fall after a ch0 rise,
    // so a step begun with ch0 high lets its pending fall pass first.
    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        case (state_q)
            IDLE: begin
                if (step_mode && req_rise) begin
                    state_d = STEP;
                    seen_d  = 1'b0;
                end
            end
            STEP: begin
                if (!step_mode || !enable[0]) begin
                    state_d = IDLE;
                end else begin
                    if (tick_d[0]) begin
                        seen_d = 1'b1;
                    end
                    if (fall_d[0] && seen_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Step FSM state register and step_req edge register.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= IDLE;
            seen_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            req_q   <= step_req;
        end
    end

    // Step FSM outputs.
    always_comb begin
        busy = (state_q == STEP);
    end

    assign clock_out = clk_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: stimulus pushes the edge numbers
// at which ticks and busy transitions must appear; a monitor pops and compares.
module tb_clock_divider_multi;

    logic       clk;
    logic       reset;
    logic [1:0] div_load;
    logic [27:0] div_value;
    logic [1:0] enable;
    logic       step_mode;
    logic       step_req;
    logic [1:0] clock_out;
    logic [1:0] tick;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int exp_t0[$];
    int exp_t1[$];
    int exp_bc[$];
    bit exp_bl[$];
    logic busy_prev = 1'b0;

    clock_divider_multi #(
        .CHANNELS(2),
        .WIDTH(28),
        .DEFAULT_DIV(10)
    ) dut (
        .clock_in(clk),
        .reset(reset),
        .div_load(div_load),
        .div_value(div_value),
        .enable(enable),
        .step_mode(step_mode),
        .step_req(step_req),
        .clock_out(clock_out),
        .tick(tick),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after posedge number k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic to_edge(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ticks(input int ch, input int first, input int period, input int n);
        for (int i = 0; i < n; i++) begin
            if (ch == 0) exp_t0.push_back(first + i * period);
            else         exp_t1.push_back(first + i * period);
        end
    endtask

    task automatic push_busy(input int c, input bit lvl);
        exp_bc.push_back(c);
        exp_bl.push_back(lvl);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_tick(input int ch);
        int e;
        e = -1;
        if (ch == 0) begin
            if (exp_t0.size() != 0) e = exp_t0.pop_front();
        end else begin
            if (exp_t1.size() != 0) e = exp_t1.pop_front();
        end
        total++;
        if (e != cyc) begin
            bad++;
            $display("FAIL tick%0d: tick seen at edge %0d, expected edge %0d", ch, cyc, e);
        end
    endtask

    // Monitor: every tick pulse and busy transition must match the next queued entry.
    always @(negedge clk) begin
        if (tick[0] === 1'b1) check_tick(0);
        if (tick[1] === 1'b1) check_tick(1);
        if (busy !== busy_prev) begin
            int  ec;
            bit  el;
            ec = -1;
            el = 1'b0;
            if (exp_bc.size() != 0) begin
                ec = exp_bc.pop_front();
                el = exp_bl.pop_front();
            end
            total++;
            if (ec != cyc || busy !== el) begin
                bad++;
                $display("FAIL busy: went %b at edge %0d, expected %b at edge %0d", busy, cyc, el, ec);
            end
            busy_prev = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        div_load  = 2'b00;
        div_value = '0;
        enable    = 2'b11;
        step_mode = 1'b0;
        step_req  = 1'b0;

        // Reset, then free-run with the default half-period of 10.
        to_edge(3);
        chk("reset clock_out", 32'(clock_out), 32'h0);
        chk("reset tick", 32'(tick), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        reset = 1'b0;
        push_ticks(0, 13, 20, 4);
        push_ticks(1, 13, 20, 3);
        push_ticks(1, 64, 6, 4);
        to_edge(13);
        chk("ch both high", 32'(clock_out), 32'h3);
        to_edge(23);
        chk("ch both low", 32'(clock_out), 32'h0);

        // Load ch1 = 3 mid-period (ch1 high, counter 4).
        to_edge(57);
        div_load  = 2'b10;
        div_value = 28'd3;
        to_edge(58);
        div_load  = 2'b00;
        to_edge(60);
        chk("ch1 held after load", 32'(clock_out), 32'h3);
        to_edge(61);
        chk("ch1 first toggle", 32'(clock_out), 32'h1);

        // Reset, then ch0 loaded with 0 behaves as D=1.
        to_edge(85);
        reset = 1'b1;
        to_edge(87);
        chk("reset again", 32'(clock_out), 32'h0);
        reset     = 1'b0;
        div_load  = 2'b01;
        div_value = 28'd0;
        push_ticks(0, 89, 2, 6);
        push_ticks(1, 97, 20, 1);
        to_edge(88);
        div_load = 2'b00;

        // Reset into step mode with D=4, one step from ch0 low.
        to_edge(100);
        reset = 1'b1;
        to_edge(102);
        reset     = 1'b0;
        step_mode = 1'b1;
        div_load  = 2'b11;
        div_value = 28'd4;
        push_busy(106, 1'b1);
        push_busy(114, 1'b0);
        push_ticks(0, 110, 0, 1);
        push_ticks(1, 110, 0, 1);
        to_edge(103);
        div_load = 2'b00;
        to_edge(105);
        step_req = 1'b1;
        to_edge(106);
        step_req = 1'b0;
        to_edge(118);
        chk("step ends low", 32'(clock_out), 32'h0);
        chk("step idle", 32'(busy), 32'h0);

        // Held request then a repulse while busy: one step each accepted edge.
        push_busy(121, 1'b1);
        push_busy(129, 1'b0);
        push_busy(132, 1'b1);
        push_busy(140, 1'b0);
        push_ticks(0, 125, 11, 2);
        push_ticks(1, 125, 11, 2);
        to_edge(120);
        step_req = 1'b1;
        to_edge(130);
        step_req = 1'b0;
        to_edge(131);
        step_req = 1'b1;
        to_edge(133);
        step_req = 1'b0;
        to_edge(134);
        step_req = 1'b1;
        to_edge(150);
        chk("no queued step", 32'(clock_out), 32'h0);
        step_req = 1'b0;

        // Abort by dropping step_mode: free-run resumes, then drop enable[1].
        push_busy(153, 1'b1);
        push_busy(156, 1'b0);
        push_ticks(0, 157, 8, 5);
        push_ticks(1, 157, 8, 3);
        to_edge(152);
        step_req = 1'b1;
        to_edge(153);
        step_req = 1'b0;
        to_edge(155);
        step_mode = 1'b0;
        to_edge(175);
        enable = 2'b01;
        to_edge(176);
        chk("ch1 forced low", 32'(clock_out), 32'h1);

        // Step starting with ch0 high: pending fall passes first.
        to_edge(190);
        step_mode = 1'b1;
        push_busy(193, 1'b1);
        push_busy(204, 1'b0);
        push_ticks(0, 200, 0, 1);
        to_edge(192);
        step_req = 1'b1;
        to_edge(193);
        step_req = 1'b0;
        to_edge(194);
        chk("ch0 high at step", 32'(clock_out), 32'h1);

        // Abort by dropping enable[0].
        to_edge(205);
        enable = 2'b11;
        push_busy(207, 1'b1);
        push_busy(210, 1'b0);
        to_edge(206);
        step_req = 1'b1;
        to_edge(207);
        step_req = 1'b0;
        to_edge(209);
        enable = 2'b10;

        // Reset mid-step (ch1 counter left at 3 by the previous abort).
        to_edge(212);
        enable = 2'b11;
        push_busy(214, 1'b1);
        push_busy(220, 1'b0);
        push_ticks(1, 215, 0, 1);
        push_ticks(0, 218, 0, 1);
        to_edge(213);
        step_req = 1'b1;
        to_edge(214);
        step_req = 1'b0;
        to_edge(219);
        reset = 1'b1;
        to_edge(220);
        chk("mid-step reset clock_out", 32'(clock_out), 32'h0);
        chk("mid-step reset tick", 32'(tick), 32'h0);
        chk("mid-step reset busy", 32'(busy), 32'h0);
        to_edge(222);
        reset = 1'b0;
        to_edge(232);

        chk("tick0 queue drained", 32'(exp_t0.size()), 32'h0);
        chk("tick1 queue drained", 32'(exp_t1.size()), 32'h0);
        chk("busy queue drained", 32'(exp_bc.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
